// File: rtl/oram_resp_checker_pkg.sv
// Shared definitions for the ORAM frontend traffic generator and response checker:
// command encodings, block geometry and the address-derived data pattern.
package oram_resp_checker_pkg;

  localparam int PKG_ORAMU    = 32;
  localparam int PKG_ORAMB    = 512;
  localparam int PKG_FEDWIDTH = 64;
  localparam int PKG_CHUNKS   = PKG_ORAMB / PKG_ORAMU;
  localparam int PKG_BEATS    = PKG_ORAMB / PKG_FEDWIDTH;

  typedef enum logic [1:0] {
    BECMD_Update  = 2'd0,
    BECMD_Append  = 2'd1,
    BECMD_Read    = 2'd2,
    BECMD_ReadRmv = 2'd3
  } becmd_e;

  // Chunk i of the block for address paddr carries paddr + i, wrapping modulo 2^ORAMU.
  function automatic logic [PKG_ORAMB-1:0] expected_block(input logic [PKG_ORAMU-1:0] paddr);
    logic [PKG_ORAMB-1:0] blk;
    blk = '0;
    for (int i = 0; i < PKG_CHUNKS; i++) begin
      blk[i*PKG_ORAMU +: PKG_ORAMU] = paddr + PKG_ORAMU'(i);
    end
    return blk;
  endfunction

endpackage

// File: rtl/oram_resp_tag_fifo.sv
// Circular FIFO holding read addresses until their response block completes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module oram_resp_tag_fifo #(
  parameter int ORAMU    = 32,
  parameter int TagDepth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [ORAMU-1:0] din,
  output logic [ORAMU-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (TagDepth > 1) ? $clog2(TagDepth) : 1;

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [ORAMU-1:0] mem_q [TagDepth];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/oram_resp_checker.sv
// Passive ORAM response checker: snoops read commands, reassembles response blocks,
// compares them against the address-derived pattern and reports statistics and Done.
module oram_resp_checker
  import oram_resp_checker_pkg::*;
#(
  parameter int          ORAMU         = PKG_ORAMU,
  parameter int          ORAMB         = PKG_ORAMB,
  parameter int          FEDWidth      = PKG_FEDWIDTH,
  parameter int          BECMDWidth    = 2,
  parameter int          TagDepth      = 8,
  parameter int          CntWidth      = 32,
  parameter logic [31:0] FakePattern   = 32'hdeadbeef,
  parameter int          IdleThreshold = 20000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic [BECMDWidth-1:0] ORAMCommand,
  input  logic [ORAMU-1:0]      ORAMPAddr,
  input  logic                  ORAMCommandValid,
  input  logic                  ORAMCommandReady,
  input  logic [FEDWidth-1:0]   ORAMDataOut,
  input  logic                  ORAMDataOutValid,
  output logic                  ORAMDataOutReady,
  output logic [CntWidth-1:0]   ReadsIssued,
  output logic [CntWidth-1:0]   ReadsReceived,
  output logic [CntWidth-1:0]   MismatchCount,
  output logic [ORAMU-1:0]      FirstErrAddr,
  output logic                  ErrorSticky,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  Done
);

  localparam int NBEATS = ORAMB / FEDWidth;
  localparam int BIW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int NWORDS = ORAMB / 32;
  localparam int IDLEW  = $clog2(IdleThreshold + 1);
  localparam logic [BIW-1:0]   LAST_BEAT = BIW'(NBEATS - 1);
  localparam logic [IDLEW-1:0] IDLE_MAX  = IDLEW'(IdleThreshold);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic all_fake(input logic [ORAMB-1:0] b);
    for (int i = 0; i < NWORDS; i++) begin
      if (b[i*32 +: 32] != FakePattern) return 1'b0;
    end
    return 1'b1;
  endfunction

  logic                rdy_q, rdy_d;
  logic [BIW-1:0]      beat_idx_q, beat_idx_d;
  logic [ORAMB-1:0]    asm_q, asm_d;
  logic                chk_vld_q, chk_vld_d;
  logic                chk_tag_q, chk_tag_d;
  logic [ORAMB-1:0]    chk_blk_q, chk_blk_d;
  logic [ORAMU-1:0]    chk_addr_q, chk_addr_d;
  logic [CntWidth-1:0] ri_q, ri_d;
  logic [CntWidth-1:0] rr_q, rr_d;
  logic [CntWidth-1:0] mm_q, mm_d;
  logic [ORAMU-1:0]    first_q, first_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                und_q, und_d;
  logic [IDLEW-1:0]    idle_q, idle_d;

  logic             cmd_xfer, is_read, beat, last_beat, activity, blk_pass;
  logic [ORAMB-1:0] blk_cur;
  logic [ORAMU-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;

  assign cmd_xfer  = ORAMCommandValid && ORAMCommandReady;
  assign is_read   = cmd_xfer && (ORAMCommand != BECMDWidth'(BECMD_Update))
                              && (ORAMCommand != BECMDWidth'(BECMD_Append));
  assign beat      = ORAMDataOutValid && rdy_q;
  assign last_beat = beat && (beat_idx_q == LAST_BEAT);
  assign activity  = cmd_xfer || beat;
  assign blk_pass  = (chk_blk_q == expected_block(chk_addr_q)) || all_fake(chk_blk_q);

  oram_resp_tag_fifo #(
    .ORAMU    (ORAMU),
    .TagDepth (TagDepth)
  ) u_tag_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .clr   (Clear),
    .push  (is_read),
    .pop   (last_beat),
    .din   (ORAMPAddr),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    blk_cur = asm_q;
    blk_cur[int'(beat_idx_q)*FEDWidth +: FEDWidth] = ORAMDataOut;
  end

  always_comb begin
    rdy_d      = 1'b1;
    beat_idx_d = beat_idx_q;
    asm_d      = asm_q;
    chk_vld_d  = 1'b0;
    chk_tag_d  = chk_tag_q;
    chk_blk_d  = chk_blk_q;
    chk_addr_d = chk_addr_q;
    ri_d       = ri_q;
    rr_d       = rr_q;
    mm_d       = mm_q;
    first_d    = first_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    und_d      = und_q;
    idle_d     = idle_q;

    if (Clear) begin
      beat_idx_d = '0;
      chk_tag_d  = 1'b0;
      ri_d       = '0;
      rr_d       = '0;
      mm_d       = '0;
      first_d    = '0;
      err_d      = 1'b0;
      ovf_d      = 1'b0;
      und_d      = 1'b0;
      idle_d     = '0;
    end else begin
      if (beat) begin
        asm_d      = blk_cur;
        beat_idx_d = last_beat ? '0 : beat_idx_q + 1'b1;
      end
      // Last beat: hand the whole block and the head tag to the check stage.
      if (last_beat) begin
        chk_vld_d  = 1'b1;
        chk_blk_d  = blk_cur;
        chk_addr_d = fifo_dout;
        chk_tag_d  = !fifo_empty;
        if (fifo_empty) und_d = 1'b1;
      end
      if (is_read) begin
        ri_d = sat_inc(ri_q);
        if (fifo_full && !last_beat) ovf_d = 1'b1;
      end
      // Check stage resolves one edge after capture.
      if (chk_vld_q) begin
        rr_d = sat_inc(rr_q);
        if (chk_tag_q && !blk_pass) begin
          mm_d  = sat_inc(mm_q);
          err_d = 1'b1;
          if (!err_q) first_d = chk_addr_q;
        end
      end
      if (activity)                idle_d = '0;
      else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rdy_q      <= 1'b0;
      beat_idx_q <= '0;
      chk_vld_q  <= 1'b0;
      chk_tag_q  <= 1'b0;
      ri_q       <= '0;
      rr_q       <= '0;
      mm_q       <= '0;
      first_q    <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
      idle_q     <= '0;
    end else begin
      rdy_q      <= rdy_d;
      beat_idx_q <= beat_idx_d;
      chk_vld_q  <= chk_vld_d;
      chk_tag_q  <= chk_tag_d;
      ri_q       <= ri_d;
      rr_q       <= rr_d;
      mm_q       <= mm_d;
      first_q    <= first_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      und_q      <= und_d;
      idle_q     <= idle_d;
    end
  end

  always_ff @(posedge Clock) begin
    asm_q      <= asm_d;
    chk_blk_q  <= chk_blk_d;
    chk_addr_q <= chk_addr_d;
  end

  assign ORAMDataOutReady = rdy_q;
  assign ReadsIssued      = ri_q;
  assign ReadsReceived    = rr_q;
  assign MismatchCount    = mm_q;
  assign FirstErrAddr     = first_q;
  assign ErrorSticky      = err_q;
  assign Overflow         = ovf_q;
  assign Underflow        = und_q;
  assign Done             = (ri_q == rr_q) && fifo_empty && !chk_vld_q
                            && (idle_q == IDLE_MAX) && !activity;

endmodule
